// File: rtl/sw_debounce.sv
// sw_debounce: per-bit synchroniser + debounce counter with change strobe; SW_DEBOUNCE_EVENT_EN adds sticky event flags and irq
module sw_debounce #(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_SW,
    output logic [WIDTH-1:0] o_SW,
    output logic             o_changed,
    input  logic [WIDTH-1:0] i_ack,
    output logic [WIDTH-1:0] o_event,
    output logic             o_irq
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] s, flip;
    assign s = sync_q[SYNC_STAGES-1];
    always_ff @(posedge clk or negedge reset)
        if (!reset)
            sync_q <= '0;
        else
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_SW};
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic [CW-1:0] cnt;
        assign flip[i] = s[i] != o_SW[i] && cnt == LAST;
        // flipping at LAST keeps the count from ever passing it
        always_ff @(posedge clk or negedge reset)
            if (!reset)
                cnt <= '0;
            else
                cnt <= (s[i] == o_SW[i] || flip[i]) ? '0 : cnt + 1'b1;
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            o_SW      <= '0;
            o_changed <= 1'b0;
        end else begin
            o_SW      <= o_SW ^ flip;
            o_changed <= |flip;
        end
`ifdef SW_DEBOUNCE_EVENT_EN
    // a flip on the same edge as its ack keeps the flag set
    always_ff @(posedge clk or negedge reset)
        if (!reset)
            o_event <= '0;
        else
            o_event <= (o_event & ~i_ack) | flip;
    assign o_irq = |o_event;
`else
    logic unused_ack;
    assign unused_ack = ^i_ack;
    assign o_event    = '0;
    assign o_irq      = 1'b0;
`endif
endmodule

// File: tb/tb_sw_debounce.sv
// tb_sw_debounce: table vectors, hand corner sequences and random stimulus against a sample-window reference model
module tb_sw_debounce;
    localparam int W = 8, S = 2, D = 4;
`ifdef SW_DEBOUNCE_EVENT_EN
    localparam bit EV = 1'b1;
`else
    localparam bit EV = 1'b0;
`endif
    logic clk = 1'b0, reset;
    logic [W-1:0] i_SW, o_SW, i_ack, o_event;
    logic o_changed, o_irq;

    sw_debounce #(.WIDTH(W), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .reset(reset), .i_SW(i_SW), .o_SW(o_SW), .o_changed(o_changed),
        .i_ack(i_ack), .o_event(o_event), .o_irq(o_irq)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", n, act, exp, $time);
        end
    endtask

    // Model: i_SW samples taken at each edge; bit flips when the D samples
    // that reached the last sync stage before this edge all differ from it.
    logic [W-1:0] hist[$];
    logic [W-1:0] mo, mev;
    logic mchg;

    task automatic model_reset;
        hist.delete();
        for (int i = 0; i < S + D - 1; i++) hist.push_back('0);
        mo = '0; mev = '0; mchg = 1'b0;
    endtask

    task automatic model_edge(input logic [W-1:0] sw, input logic [W-1:0] ack);
        logic [W-1:0] fl;
        fl = '0;
        hist.push_back(sw);
        for (int b = 0; b < W; b++) begin
            bit all;
            all = 1'b1;
            for (int k = 0; k < D; k++)
                if (hist[k][b] == mo[b]) all = 1'b0;
            fl[b] = all;
        end
        void'(hist.pop_front());
        mo   = mo ^ fl;
        mchg = |fl;
        mev  = (mev & ~ack) | fl;
        if (!EV) mev = '0;
    endtask

    task automatic step(input logic [W-1:0] sw, input logic [W-1:0] ack);
        i_SW = sw; i_ack = ack;
        @(posedge clk);
        @(negedge clk);
        model_edge(sw, ack);
        chk("mdl_sw", o_SW, mo);
        chk("mdl_chg", o_changed, mchg);
        chk("mdl_ev", o_event, mev);
        chk("mdl_irq", o_irq, |mev);
    endtask

    typedef struct {
        logic [W-1:0] sw;
        logic [W-1:0] exp_sw;
        logic         exp_chg;
    } vec_t;
    vec_t tv[$];

    task automatic seg(input logic [W-1:0] sw, input int n, input logic [W-1:0] old_v,
                       input logic [W-1:0] new_v, input int flip_at);
        for (int i = 1; i <= n; i++)
            tv.push_back('{sw, (i < flip_at) ? old_v : new_v, i == flip_at});
    endtask

    initial begin
        logic [W-1:0] cur;
        seg(8'hFF, 7, 8'h00, 8'hFF, 6);
        seg(8'hAA, 7, 8'hFF, 8'hAA, 6);
        seg(8'h00, 7, 8'hAA, 8'h00, 6);
        seg(8'h01, 3, 8'h00, 8'h00, 99);
        seg(8'h00, 1, 8'h00, 8'h00, 99);
        seg(8'h01, 3, 8'h00, 8'h00, 99);
        seg(8'h00, 6, 8'h00, 8'h00, 99);

        reset = 1'b0; i_SW = 8'hFF; i_ack = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_sw", o_SW, 8'h00);
        chk("rst_chg", o_changed, 1'b0);
        chk("rst_ev", o_event, 8'h00);
        chk("rst_irq", o_irq, 1'b0);
        reset = 1'b1;

        foreach (tv[i]) begin
            step(tv[i].sw, '0);
            chk("tbl_sw", o_SW, tv[i].exp_sw);
            chk("tbl_chg", o_changed, tv[i].exp_chg);
        end

        repeat (7) step(8'hFF, '0);
        step(8'hFF, 8'hFF);
        chk("ack_all_ev", o_event, 8'h00);
        repeat (7) step(8'hAA, '0);
        chk("ev_55", o_event, EV ? 8'h55 : 8'h00);
        chk("irq_on", o_irq, EV);
        step(8'hAA, 8'h05);
        chk("ev_50", o_event, EV ? 8'h50 : 8'h00);
        repeat (5) step(8'hBA, '0);
        step(8'hBA, 8'h10);
        chk("set_wins_sw", o_SW, 8'hBA);
        chk("set_wins_ev", o_event, EV ? 8'h50 : 8'h00);
        step(8'hBA, 8'hFF);
        chk("irq_off", o_irq, 1'b0);
        chk("ev_clr", o_event, 8'h00);

        repeat (7) step(8'h00, '0);
        repeat (3) step(8'h0F, '0);
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        model_reset();
        chk("midrst_sw", o_SW, 8'h00);
        chk("midrst_chg", o_changed, 1'b0);
        chk("midrst_ev", o_event, 8'h00);
        chk("midrst_irq", o_irq, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (5) step(8'h0F, '0);
        chk("rel_pre", o_SW, 8'h00);
        step(8'h0F, '0);
        chk("rel_sw", o_SW, 8'h0F);
        chk("rel_chg", o_changed, 1'b1);
        step(8'h0F, '0);
        chk("rel_chg_end", o_changed, 1'b0);

        cur = 8'h0F;
        for (int i = 0; i < 600; i++) begin
            logic [W-1:0] ack;
            if ($urandom_range(0, 2) == 0) cur = cur ^ W'(1 << $urandom_range(0, W - 1));
            if ($urandom_range(0, 9) == 0) cur = cur ^ W'($urandom);
            ack = ($urandom_range(0, 5) == 0) ? W'($urandom) : '0;
            step(cur, ack);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
